// File: rtl/bn_act_stream.sv
// Streaming per-channel batch-norm + activation over a channel-interleaved stream.
// Optional feature: define BNACT_LEAKY_EN for leaky (slope 1/8) on act_mode 2; otherwise mode 2 acts as ReLU.
module bn_act_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int COEF_WIDTH = 16,
    parameter int FRAC_WIDTH = 8,
    parameter int CHANNELS   = 64,
    parameter int PIXELS     = 65536
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [1:0]                    act_mode,
    input  logic                          cfg_we,
    input  logic [$clog2(CHANNELS)-1:0]   cfg_addr,
    input  logic [COEF_WIDTH-1:0]         cfg_scale,
    input  logic [DATA_WIDTH-1:0]         cfg_bias,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          busy,
    output logic                          done,
    output logic                          sat_flag
);
    localparam int AW = $clog2(CHANNELS);
    localparam int PW = DATA_WIDTH + COEF_WIDTH;
    localparam int SW = PW + 1;
    localparam logic [31:0]              TOTAL   = 32'(PIXELS * CHANNELS);
    localparam logic [AW-1:0]            CH_LAST = AW'(CHANNELS - 1);
    localparam logic signed [COEF_WIDTH-1:0] ONE = COEF_WIDTH'(1) << FRAC_WIDTH;
    localparam logic signed [SW-1:0]     HALF    = SW'(1) << (FRAC_WIDTH - 1);
    localparam logic signed [SW-1:0]     MAXV    = {{(SW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0]     MINV    = {{(SW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] in_cnt_q, in_cnt_d;
    logic [31:0] out_cnt_q, out_cnt_d;
    logic [AW-1:0] ch_q, ch_d;
    logic [1:0]  mode_q, mode_d;
    logic        sat_q, sat_d;

    logic signed [COEF_WIDTH-1:0] scale_q [CHANNELS];
    logic signed [DATA_WIDTH-1:0] bias_q  [CHANNELS];

    logic                         s1_v_q, s2_v_q, s3_v_q, out_v_q;
    logic signed [DATA_WIDTH-1:0] s1_x_q, s2_x_q;
    logic [AW-1:0]                s1_c_q;
    logic signed [COEF_WIDTH-1:0] s2_scale_q;
    logic signed [DATA_WIDTH-1:0] s2_bias_q, s3_bias_q;
    logic signed [PW-1:0]         s3_p_q;
    logic signed [DATA_WIDTH-1:0] out_data_q;

    logic stall, in_acc, out_acc;
    logic signed [PW-1:0]         prod;
    logic signed [SW-1:0]         rnd_sum, rnd, sum;
    logic signed [DATA_WIDTH-1:0] sat_val, act_val;
    logic                         sat_hit;

    assign stall     = out_v_q && !out_ready;
    assign in_ready  = (state_q == S_RUN) && !stall;
    assign in_acc    = in_valid && in_ready;
    assign out_acc   = out_v_q && out_ready;
    assign out_valid = out_v_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign sat_flag  = sat_q;

    // Datapath: multiply, round half-up, add bias, saturate, activate.
    always_comb begin
        prod    = PW'(s2_x_q) * PW'(s2_scale_q);
        rnd_sum = SW'(s3_p_q) + HALF;
        rnd     = rnd_sum >>> FRAC_WIDTH;
        sum     = rnd + SW'(s3_bias_q);
        sat_hit = 1'b0;
        if (sum > MAXV) begin
            sat_val = MAXV[DATA_WIDTH-1:0];
            sat_hit = 1'b1;
        end else if (sum < MINV) begin
            sat_val = MINV[DATA_WIDTH-1:0];
            sat_hit = 1'b1;
        end else begin
            sat_val = sum[DATA_WIDTH-1:0];
        end
        act_val = sat_val;
        case (mode_q)
            2'd1: if (sat_val[DATA_WIDTH-1]) act_val = '0;
`ifdef BNACT_LEAKY_EN
            2'd2: if (sat_val[DATA_WIDTH-1]) act_val = sat_val >>> 3;
`else
            2'd2: if (sat_val[DATA_WIDTH-1]) act_val = '0;
`endif
            default: act_val = sat_val;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        ch_d      = ch_q;
        mode_d    = mode_q;
        sat_d     = sat_q;
        if (!stall && s3_v_q && sat_hit) sat_d = 1'b1;
        if (out_acc) out_cnt_d = out_cnt_q + 32'd1;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_RUN;
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                    ch_d      = '0;
                    sat_d     = 1'b0;
                    mode_d    = act_mode;
                end
            end
            S_RUN: begin
                if (in_acc) begin
                    in_cnt_d = in_cnt_q + 32'd1;
                    ch_d     = (ch_q == CH_LAST) ? '0 : ch_q + AW'(1);
                    if (in_cnt_q == TOTAL - 32'd1) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_acc && out_cnt_q == TOTAL - 32'd1) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            ch_q      <= '0;
            mode_q    <= '0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            ch_q      <= ch_d;
            mode_q    <= mode_d;
            sat_q     <= sat_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                scale_q[i] <= ONE;
                bias_q[i]  <= '0;
            end
        end else if (cfg_we && state_q == S_IDLE) begin
            scale_q[cfg_addr] <= cfg_scale;
            bias_q[cfg_addr]  <= cfg_bias;
        end
    end

    // Four register ranks (capture, table read, multiply, output) give the
    // three-edge accept-to-out_valid latency; the whole chain freezes on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q     <= 1'b0;
            s1_x_q     <= '0;
            s1_c_q     <= '0;
            s2_v_q     <= 1'b0;
            s2_x_q     <= '0;
            s2_scale_q <= '0;
            s2_bias_q  <= '0;
            s3_v_q     <= 1'b0;
            s3_p_q     <= '0;
            s3_bias_q  <= '0;
            out_v_q    <= 1'b0;
            out_data_q <= '0;
        end else if (!stall) begin
            s1_v_q <= in_acc;
            if (in_acc) begin
                s1_x_q <= in_data;
                s1_c_q <= ch_q;
            end
            s2_v_q <= s1_v_q;
            if (s1_v_q) begin
                s2_x_q     <= s1_x_q;
                s2_scale_q <= scale_q[s1_c_q];
                s2_bias_q  <= bias_q[s1_c_q];
            end
            s3_v_q <= s2_v_q;
            if (s2_v_q) begin
                s3_p_q    <= prod;
                s3_bias_q <= s2_bias_q;
            end
            out_v_q <= s3_v_q;
            if (s3_v_q) out_data_q <= act_val;
        end
    end
endmodule

// File: tb/tb_bn_act_stream.sv
// Scoreboard bench for bn_act_stream: directed frames push hand-computed results, a monitor pops on each output transfer.
module tb_bn_act_stream;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  act_mode = 2'd0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = 2'd0;
    logic [15:0] cfg_scale = '0;
    logic [15:0] cfg_bias = '0;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        busy;
    logic        done;
    logic        sat_flag;

    always #5 clk = ~clk;

    bn_act_stream #(
        .DATA_WIDTH(16), .COEF_WIDTH(16), .FRAC_WIDTH(8), .CHANNELS(4), .PIXELS(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .act_mode(act_mode),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_scale(cfg_scale), .cfg_bias(cfg_bias),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .sat_flag(sat_flag)
    );

    int          tests = 0;
    int          fails = 0;
    int          pops = 0;
    int          done_cnt = 0;
    bit          rand_bp = 1'b0;
    bit          prev_stall = 1'b0;
    logic [15:0] prev_data = '0;
    logic [15:0] exp_q [$];
    logic [15:0] vx [16];
    logic [15:0] ve [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lk(input logic [15:0] v);
`ifdef BNACT_LEAKY_EN
        return v;
`else
        return 16'h0000;
`endif
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_data", 32'(out_data), 32'(prev_data));
            end
            if (done) done_cnt++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_out: got %h expected no output", out_data);
                end else begin
                    chk($sformatf("out[%0d]", pops), 32'(out_data), 32'(exp_q.pop_front()));
                    pops++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    always @(posedge clk) begin
        #1;
        out_ready = rand_bp ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    initial begin
        #500000;
        fails++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input logic [1:0] ch, input logic [15:0] sc, input logic [15:0] bi);
        cfg_we = 1'b1; cfg_addr = ch; cfg_scale = sc; cfg_bias = bi;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic do_start(input logic [1:0] mode, input bit wcfg, input logic [15:0] sc, input logic [15:0] bi);
        start = 1'b1; act_mode = mode;
        if (wcfg) begin
            cfg_we = 1'b1; cfg_addr = 2'd0; cfg_scale = sc; cfg_bias = bi;
        end
        tick();
        start = 1'b0; cfg_we = 1'b0; act_mode = mode ^ 2'b11;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_sat_clr", 32'(sat_flag), 32'd0);
    endtask

    task automatic send(input logic [15:0] x, input logic [15:0] e);
        int n = 0;
        in_data = x; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got in_ready=0 expected 1");
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic finish_frame(input string tag, input logic exp_sat);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 1000);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy_in_done"}, 32'(busy), 32'd1);
        chk({tag, "_sat"}, 32'(sat_flag), 32'(exp_sat));
        @(negedge clk);
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_outputs"}, 32'(pops), 32'd16);
        chk({tag, "_done_count"}, 32'(done_cnt), 32'd1);
        chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        tick();
    endtask

    task automatic run_frame(input string tag, input logic [1:0] mode, input bit bp, input logic exp_sat,
                             input bit lat_chk, input bit poke, input bit wcfg,
                             input logic [15:0] sc, input logic [15:0] bi);
        pops = 0; done_cnt = 0; rand_bp = bp;
        do_start(mode, wcfg, sc, bi);
        if (poke) begin
            // Busy: both the write and the restart must be ignored.
            cfg_we = 1'b1; cfg_addr = 2'd0; cfg_scale = 16'h0000; cfg_bias = 16'h7FFF;
            start = 1'b1; act_mode = 2'd0;
            tick();
            cfg_we = 1'b0; start = 1'b0;
        end
        for (int i = 0; i < 16; i++) begin
            send(vx[i], ve[i]);
            if (lat_chk && i == 0) begin
                repeat (3) @(negedge clk);
                chk({tag, "_lat_early"}, 32'(out_valid), 32'd0);
                @(negedge clk);
                chk({tag, "_lat_n3"}, 32'(out_valid), 32'd1);
                tick();
            end
        end
        finish_frame(tag, exp_sat);
        rand_bp = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sat", 32'(sat_flag), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        rst_n = 1'b1;
        tick();

        // Identity table from reset: out == in, including extremes.
        vx = '{16'h1234, 16'hFEDC, 16'h7FFF, 16'h8000, 16'h0000, 16'h0001, 16'hFFFF, 16'h0100,
               16'h4000, 16'hC000, 16'h00FF, 16'hFF01, 16'h5555, 16'hAAAA, 16'h0080, 16'hFF80};
        ve = vx;
        run_frame("ident", 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0);

        do_cfg(2'd0, 16'h0180, 16'hFF00);
        do_cfg(2'd1, 16'hFF00, 16'h0000);
        do_cfg(2'd2, 16'h0400, 16'h0000);
        do_cfg(2'd3, 16'h0400, 16'h0000);
        vx = '{16'h0200, 16'h0100, 16'h7000, 16'h9000,  16'h0000, 16'hFF00, 16'h0010, 16'hFFF0,
               16'h0100, 16'h8000, 16'h2000, 16'h1FFF,  16'h0001, 16'h0001, 16'h0000, 16'hE000};
        ve = '{16'h0200, 16'hFF00, 16'h7FFF, 16'h8000,  16'hFF00, 16'h0100, 16'h0040, 16'hFFC0,
               16'h0080, 16'h7FFF, 16'h7FFF, 16'h7FFC,  16'hFF02, 16'hFFFF, 16'h0000, 16'h8000};
        run_frame("affine", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);

        vx = '{16'h0000, 16'h0100, 16'h0010, 16'hFFF0,  16'h0200, 16'hFF00, 16'hFFF0, 16'h0010,
               16'h0000, 16'h0100, 16'h0010, 16'hFFF0,  16'h0200, 16'hFF00, 16'hFFF0, 16'h0010};
        ve = '{16'h0000, 16'h0000, 16'h0040, 16'h0000,  16'h0200, 16'h0100, 16'h0000, 16'h0040,
               16'h0000, 16'h0000, 16'h0040, 16'h0000,  16'h0200, 16'h0100, 16'h0000, 16'h0040};
        run_frame("relu", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);

        ve = '{lk(16'hFFE0), lk(16'hFFE0), 16'h0040, lk(16'hFFF8),  16'h0200, 16'h0100, lk(16'hFFF8), 16'h0040,
               lk(16'hFFE0), lk(16'hFFE0), 16'h0040, lk(16'hFFF8),  16'h0200, 16'h0100, lk(16'hFFF8), 16'h0040};
        run_frame("leaky", 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0);

        vx = '{16'h0100, 16'h0100, 16'h0010, 16'h0010,  16'h0080, 16'h0200, 16'h0020, 16'hFFE0,
               16'h0100, 16'h0100, 16'h0010, 16'h0010,  16'h0080, 16'h0200, 16'h0020, 16'hFFE0};
        ve = '{16'h0200, 16'hFF00, 16'h0040, 16'h0040,  16'h0100, 16'hFE00, 16'h0080, 16'hFF80,
               16'h0200, 16'hFF00, 16'h0040, 16'h0040,  16'h0100, 16'hFE00, 16'h0080, 16'hFF80};
        run_frame("start_cfg", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0200, 16'h0000);

        // Abort after seven accepted samples.
        pops = 0; done_cnt = 0;
        do_start(2'd0, 1'b0, '0, '0);
        for (int i = 0; i < 7; i++) send(vx[i], ve[i]);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_out_data", 32'(out_data), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) tick();
        chk("abort_no_done", 32'(done_cnt), 32'd0);

        vx = '{16'h1234, 16'hFEDC, 16'h7FFF, 16'h8000, 16'h0000, 16'h0001, 16'hFFFF, 16'h0100,
               16'h4000, 16'hC000, 16'h00FF, 16'hFF01, 16'h5555, 16'hAAAA, 16'h0080, 16'hFF80};
        ve = vx;
        run_frame("post_abort", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
